legv8_fetch_unit: RTL and testbench

Instruction fetch stage for the LEGv8 core. It sits directly upstream of the LEGv8 control unit. It owns the program counter and requests instruction words from instruction memory over a req/ack handshake. It presents one instruction at a time to the control unit with a valid/ready handshake, and applies the next-PC selection (sequential, PC-relative, or register) returned by the control unit when that instruction is consumed.

---
 rtl/legv8_fetch_unit.sv | 126 ++++++++++++
 tb/tb_legv8_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_fetch_unit.sv
// legv8_fetch_unit: instruction fetch stage for the LEGv8 core.
//
// Owns the program counter and fetches one word at a time from instruction
// memory over a req/ack handshake. It holds that word for the control unit
// under a valid/ready handshake. When the word is consumed, it applies the
// next-PC selection returned by the control unit.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   REQ   | issue request for pc (first cycle after reset/consume arms req)
//   WAIT  | request outstanding, memory has not acked yet
//   HOLD  | instruction held and valid, waiting for the control unit
//   HALT  | misaligned register target seen; frozen until reset
//
// imem_req is a registered output. On reset the FSM enters REQ with
// imem_req low. The first REQ cycle after reset is only used to raise
// imem_req, so any acks still arriving from the aborted fetch are dropped.
// After a consume, the FSM enters REQ with imem_req already high. This keeps
// the zero-wait throughput at one instruction every two cycles.

module legv8_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic [1:0]  pc_sel,
    input  logic [63:0] branch_offset,
    input  logic [63:0] branch_target,
    output logic [63:0] pc,
    output logic [63:0] pc_plus4,
    output logic        align_fault,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t      state;
    logic [63:0] offset_bytes;
    logic [63:0] next_pc;
    logic        target_misaligned;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 64'd4;

    // Next-PC selection; the word offset's top two bits fall off the shift.
    always_comb begin
        offset_bytes      = branch_offset << 2;
        next_pc           = pc_plus4;
        target_misaligned = 1'b0;
        case (pc_sel)
            2'b01:   next_pc = pc + offset_bytes;
            2'b10: begin
                next_pc           = branch_target;
                target_misaligned = (branch_target[1:0] != 2'b00);
            end
            default: next_pc = pc_plus4;
        endcase
    end

    // Fetch FSM with registered handshake outputs, PC and counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= REQ;
            pc          <= RESET_PC;
            instruction <= 32'h0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            align_fault <= 1'b0;
            instr_count <= 32'h0;
        end else begin
            case (state)
                REQ: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        instruction <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= HOLD;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        instruction <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        instr_count <= instr_count + 32'd1;
                        pc          <= next_pc;
                        if (target_misaligned) begin
                            align_fault <= 1'b1;
                            state       <= HALT;
                        end else begin
                            imem_req <= 1'b1;
                            state    <= REQ;
                        end
                    end
                end
                default: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_legv8_fetch_unit.sv
// tb_legv8_fetch_unit: directed, table-driven bench for legv8_fetch_unit.
// A behavioural instruction memory returns addr[31:0]^32'h5A5A_0F0F after a
// programmable number of wait cycles.

module tb_legv8_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        mem_ack = 1'b0;
    logic        manual_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [1:0]  pc_sel = 2'b00;
    logic [63:0] branch_offset = 64'h0;
    logic [63:0] branch_target = 64'h0;
    logic [63:0] pc;
    logic [63:0] pc_plus4;
    logic        align_fault;
    logic [31:0] instr_count;

    int n_checks = 0;
    int n_fail   = 0;
    int mem_delay = 0;
    int wait_cnt  = 0;

    legv8_fetch_unit #(.RESET_PC(64'h0)) dut (
        .clock        (clock),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (mem_ack | manual_ack),
        .imem_rdata   (manual_ack ? 32'hDEAD_BEEF : mem_rdata),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .pc_sel       (pc_sel),
        .branch_offset(branch_offset),
        .branch_target(branch_target),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .align_fault  (align_fault),
        .instr_count  (instr_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0F0F;
    endfunction

    // Memory model: acks after mem_delay cycles of continuous request.
    always @(negedge clock) begin
        mem_ack = 1'b0;
        if (!imem_req) begin
            wait_cnt = 0;
        end else if (wait_cnt >= mem_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_word(imem_addr);
            wait_cnt  = 0;
        end else begin
            wait_cnt = wait_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (instr_valid) break;
        end
        check({name, "_valid_timeout"}, instr_valid, 1);
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [63:0] off;
        logic [63:0] tgt;
        int          delay;
        logic [63:0] cur_pc;
        logic [63:0] nxt_pc;
        logic        fault;
    } vec_t;

    vec_t vecs[10];
    int   req_cycles;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{2'b00, 64'h0, 64'h0, 0, 64'h0, 64'h4, 1'b0};
        vecs[1] = '{2'b11, 64'h0, 64'h0, 1, 64'h4, 64'h8, 1'b0};
        vecs[2] = '{2'b10, 64'h0, 64'h100, 2, 64'h8, 64'h100, 1'b0};
        vecs[3] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 0, 64'h100, 64'hF8, 1'b0};
        vecs[4] = '{2'b10, 64'h0, 64'h0, 3, 64'hF8, 64'h0, 1'b0};
        vecs[5] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        vecs[6] = '{2'b00, 64'h0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b0};
        vecs[7] = '{2'b01, 64'h4000_0000_0000_0001, 64'h0, 0, 64'h0, 64'h4, 1'b0};
        vecs[8] = '{2'b10, 64'h0, 64'h2000, 2, 64'h4, 64'h2000, 1'b0};
        vecs[9] = '{2'b10, 64'h0, 64'h2002, 0, 64'h2000, 64'h2002, 1'b1};

        // Reset state
        do_reset();
        check("rst_valid", instr_valid, 0);
        check("rst_req", imem_req, 0);
        check("rst_pc", pc, 64'h0);
        check("rst_instr", instruction, 0);
        check("rst_fault", align_fault, 0);
        check("rst_count", instr_count, 0);

        // Sequential fetch, zero-wait memory, ready tied high
        mem_delay   = 0;
        instr_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock);
            #1;
            if (k % 2 == 1) begin
                check("seq_req", imem_req, 1);
                check("seq_valid_low", instr_valid, 0);
                check("seq_addr", imem_addr, 64'((k - 1) / 2 * 4));
            end else begin
                check("seq_valid", instr_valid, 1);
                check("seq_req_low", imem_req, 0);
                check("seq_pc", pc, 64'((k - 2) / 2 * 4));
                check("seq_pc4", pc_plus4, 64'((k - 2) / 2 * 4 + 4));
                check("seq_instr", instruction, mem_word(64'((k - 2) / 2 * 4)));
            end
        end
        @(posedge clock);
        #1;
        instr_ready = 1'b0;
        check("seq_count", instr_count, 4);

        // Wait states then back-pressure
        do_reset();
        mem_delay  = 3;
        req_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (instr_valid) break;
            if (imem_req) begin
                req_cycles++;
                check("wait_addr", imem_addr, 64'h0);
            end
        end
        check("wait_req_cycles", req_cycles, 4);
        check("wait_valid", instr_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check("bp_valid", instr_valid, 1);
            check("bp_req", imem_req, 0);
            check("bp_pc", pc, 64'h0);
            check("bp_instr", instruction, mem_word(64'h0));
        end

        // Table of consumes with varied next-PC selection and memory latency
        for (int i = 0; i < 10; i++) begin
            mem_delay = vecs[i].delay;
            wait_valid("tbl");
            check("tbl_pc", pc, vecs[i].cur_pc);
            check("tbl_pc4", pc_plus4, vecs[i].cur_pc + 64'd4);
            check("tbl_instr", instruction, mem_word(vecs[i].cur_pc));
            @(negedge clock);
            pc_sel        = vecs[i].sel;
            branch_offset = vecs[i].off;
            branch_target = vecs[i].tgt;
            instr_ready   = 1'b1;
            @(posedge clock);
            #1;
            instr_ready   = 1'b0;
            pc_sel        = 2'b00;
            branch_offset = 64'h0;
            branch_target = 64'h0;
            check("tbl_valid_low", instr_valid, 0);
            check("tbl_count", instr_count, 32'(i + 1));
            check("tbl_fault", align_fault, vecs[i].fault);
            check("tbl_next_pc", imem_addr, vecs[i].nxt_pc);
            check("tbl_req", imem_req, !vecs[i].fault);
        end

        // HALT holds off further fetches and ignores stray acks
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            manual_ack = 1'b1;
            @(posedge clock);
            #1;
            manual_ack = 1'b0;
            check("halt_req", imem_req, 0);
            check("halt_valid", instr_valid, 0);
            check("halt_fault", align_fault, 1);
            check("halt_pc", pc, 64'h2002);
        end
        do_reset();
        check("halt_rst_fault", align_fault, 0);
        check("halt_rst_pc", pc, 64'h0);
        check("halt_rst_count", instr_count, 0);

        // Reset during WAIT with a late ack
        mem_delay = 10;
        @(posedge clock);
        #1;
        check("mid_req1", imem_req, 1);
        @(posedge clock);
        #1;
        check("mid_req2", imem_req, 1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid_rst_req", imem_req, 0);
        @(negedge clock);
        reset      = 1'b0;
        manual_ack = 1'b1;
        @(posedge clock);
        #1;
        manual_ack = 1'b0;
        check("mid_valid", instr_valid, 0);
        check("mid_count", instr_count, 0);
        check("mid_instr", instruction, 0);
        check("mid_restart_req", imem_req, 1);
        check("mid_restart_addr", imem_addr, 64'h0);

        // instr_count wraps modulo 2^32
        mem_delay = 0;
        wait_valid("wrap");
        force dut.instr_count = 32'hFFFF_FFFF;
        @(posedge clock);
        #1;
        release dut.instr_count;
        @(negedge clock);
        instr_ready = 1'b1;
        @(posedge clock);
        #1;
        instr_ready = 1'b0;
        check("wrap_count", instr_count, 0);
        check("wrap_next_pc", imem_addr, 64'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
